// File: rtl/dac_model_if.sv
// dac_model_if: code/voltage bundle between a sample source and the DAC model
`timescale 1ns/1ps
interface dac_model_if #(parameter int NBITS = 8);
    logic [NBITS-1:0] I_data;
    // Two-state code and real voltage both start at zero from time 0, before any reset or clock
    bit [NBITS-1:0] A_code;
    real A_out;
    modport master (output I_data, input A_out, A_code);
    modport slave (input I_data, output A_out, A_code);
endinterface

// File: rtl/dac_model.sv
// dac_model: behavioural NBITS-bit DAC, registered code to real voltage 0..VREF; DAC_SLEW_EN limits output slew
`timescale 1ns/1ps
module dac_model #(
    parameter real VREF = 3.3,
    parameter int NBITS = 8,
    parameter real SLEW_STEP = 0.1
) (
    input logic clk,
    input logic rst_n,
    dac_model_if.slave bus
);
    localparam real DEN = real'((1 << NBITS) - 1);
    if (NBITS < 1 || NBITS > 16 || SLEW_STEP <= 0.0) begin : g_bad_param
        $error("dac_model: NBITS must be 1..16 and SLEW_STEP > 0");
    end
    logic [NBITS-1:0] code;
    real tgt;
    // Unknown input bits convert as code 0; target voltage is straight binary, full code maps to exactly VREF
    always_comb begin
        code = $isunknown(bus.I_data) ? '0 : bus.I_data;
        tgt = VREF * real'(code) / DEN;
    end
    // Asynchronous clear to 0 V; otherwise register the code and drive (or slew toward) its voltage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.A_code <= '0;
            bus.A_out <= 0.0;
        end else begin
            if ($isunknown(bus.I_data))
                $display("%0t dac_model: warning, X/Z on I_data, converting as 0", $time);
            bus.A_code <= code;
`ifdef DAC_SLEW_EN
            bus.A_out <= (tgt - bus.A_out > SLEW_STEP) ? bus.A_out + SLEW_STEP :
                         (bus.A_out - tgt > SLEW_STEP) ? bus.A_out - SLEW_STEP : tgt;
`else
            bus.A_out <= tgt;
`endif
        end
    end
endmodule

// File: tb/tb_dac_model.sv
// tb_dac_model: randomized and directed checks of dac_model against an arithmetic voltage model
`timescale 1ns/1ps
module tb_dac_model;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_code = 0;
    dac_model_if #(.NBITS(8)) bus();
    dac_model dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic real volts(int c);
        return 3.3 * c / 255.0;
    endfunction

    task automatic chk_r(string name, real got, real want, real tol);
        n_cmp++;
        if (got > want + tol || got < want - tol) begin
            n_bad++;
            $display("FAIL %s at %0t: A_out=%0.9f expected %0.9f", name, $time, got, want);
        end
    endtask

    task automatic chk_i(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at %0t: A_code=%0d expected %0d", name, $time, got, want);
        end
    endtask

    task automatic wait_to(realtime t);
        #(t - $realtime);
    endtask

    // Reference: the code applied when a rising edge sees reset released is what the DAC shows until the next such edge
    always @(posedge clk) if (rst_n) exp_code = int'(bus.I_data);

    // Every falling edge the outputs must equal the model's code and its linear voltage
    always @(negedge clk) begin
        chk_i("cycle code", int'(bus.A_code), exp_code);
        chk_r("cycle volt", bus.A_out, volts(exp_code), 1e-9);
    end

    initial begin
        bus.I_data = 8'd0;
        #1;
        chk_r("init volt", bus.A_out, 0.0, 0.0);
        chk_i("init code", int'(bus.A_code), 0);
        wait_to(2);
        rst_n = 1'b1;
        wait_to(8);
        chk_r("zero volt", bus.A_out, 0.0, 0.0);
        wait_to(12);
        bus.I_data = 8'hFF;
        wait_to(14);
        chk_r("latency hold", bus.A_out, 0.0, 0.0);
        wait_to(16);
        chk_r("full scale volt", bus.A_out, 3.3, 1e-9);
        chk_i("full scale code", int'(bus.A_code), 255);
        wait_to(99);
        chk_r("full scale stable", bus.A_out, 3.3, 1e-9);
        wait_to(102);
        bus.I_data = 8'd128;
        wait_to(107);
        chk_r("mid code volt", bus.A_out, 1.656471, 1e-6);
        chk_i("mid code code", int'(bus.A_code), 128);
        wait_to(112);
        bus.I_data = 8'd1;
        wait_to(117);
        chk_r("lsb volt", bus.A_out, 0.012941, 1e-6);
        wait_to(122);
        bus.I_data = 8'd0;
        wait_to(127);
        chk_r("back to zero", bus.A_out, 0.0, 0.0);
        while ($realtime < 480) begin
            @(negedge clk);
            #2 bus.I_data = 8'($urandom_range(0, 255));
            #1 bus.I_data = 8'($urandom_range(0, 255));
        end
        wait_to(487);
        bus.I_data = 8'hFF;
        wait_to(503);
        rst_n = 1'b0;
        exp_code = 0;
        #0.001;
        chk_r("async reset volt", bus.A_out, 0.0, 0.0);
        chk_i("async reset code", int'(bus.A_code), 0);
        wait_to(512);
        chk_r("reset held over edge", bus.A_out, 0.0, 0.0);
        wait_to(523);
        rst_n = 1'b1;
        wait_to(526);
        chk_r("release volt", bus.A_out, 3.3, 1e-9);
        chk_i("release code", int'(bus.A_code), 255);
        while ($realtime < 700) begin
            @(negedge clk);
            #2 bus.I_data = 8'($urandom_range(0, 255));
        end
        wait_to(713);
        rst_n = 1'b0;
        exp_code = 0;
        #0.001;
        chk_r("second reset volt", bus.A_out, 0.0, 0.0);
        wait_to(722);
        rst_n = 1'b1;
        bus.I_data = 8'd200;
        wait_to(727);
        chk_r("post reset volt", bus.A_out, 3.3 * 200.0 / 255.0, 1e-9);
        chk_i("post reset code", int'(bus.A_code), 200);
        wait_to(760);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dac_model.md
Name: dac_model

Overview:
- Behavioural 8-bit digital-to-analog converter model for simulation benches. Example: the sine-wave generator drives its sample code into this block.
- On each rising clock edge the block registers an unsigned input code and drives a real-valued output voltage, scaled linearly between 0.0 V and VREF.
- Clocked from the bench clock generator, which runs at 100 MHz (10 ns period, 50% duty).
- Simulation-only model: the analog output is a real, not synthesizable.

Parameters:
- VREF, 3.3, full-scale reference voltage (real, volts). Positional first parameter.
- NBITS, 8, input code width (integer, 1..16).
- SLEW_STEP, 0.1, maximum output change per clock in volts (real, >0). Used only with DAC_SLEW_EN.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- I_data  input  NBITS  unsigned input code.
- A_out  output  real (64-bit IEEE)  analog output voltage.
- A_code  output  NBITS  registered copy of the code currently converted, for digital checking.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - A_out = 0.0 and A_code = 0 immediately, with no clock required.
  - Outputs hold these values while rst_n=0.
- Release:
  - First conversion occurs on the first rising clk edge with rst_n=1.
  - Release is not synchronized internally; the bench deasserts rst_n away from clk edges.
- Conversion on each rising clk edge with rst_n=1:
  - A_code <= I_data.
  - A_out <= VREF * I_data / (2^NBITS - 1).
- Scaling:
  - Unsigned, straight binary.
  - Code 0 -> 0.0 V; code 2^NBITS-1 -> exactly VREF.
  - Monotonic, no offset or gain error.
- Latency:
  - Exactly 1 clock from I_data sampled at edge N to A_out/A_code valid after edge N.
  - A_out is constant between edges; I_data changes between edges are invisible.
- Arithmetic:
  - Division performed in real arithmetic; no integer truncation.
  - The denominator is computed once from NBITS.
- Unknown input: if I_data contains X/Z bits at the sampling edge, A_out = 0.0, A_code = 0, and a $display warning with $time is printed.
- Initial state: before any reset or clock, A_out = 0.0 and A_code = 0 (initialised at time 0).
- Reset mid-operation: asynchronous clear wins over any concurrent clock edge; the output returns to 0.0 in the same timestep.

Optional Feature:
- Macro: DAC_SLEW_EN.
- When defined:
  - A_out moves toward the target value VREF*A_code/(2^NBITS-1) by at most SLEW_STEP per rising clk.
  - If |target - A_out| <= SLEW_STEP, A_out = target exactly.
  - A_code still updates with 1-clock latency.
  - Reset still forces A_out=0.0 immediately, with no slewing.
- When undefined: A_out reaches the target in 1 clock as above, and SLEW_STEP is ignored.

Test Plan:
- Full scale: I_data=8'hFF held, VREF=3.3, rst_n=1, 100 MHz clk -> A_out=3.3 (±1e-9) and A_code=255 after the first rising edge; stable through 1000 ns.
- Zero: I_data=8'h00 -> A_out=0.0, A_code=0 after the next edge.
- Mid code: I_data=128 -> A_out=1.656471 (±1e-6); I_data=1 -> 0.012941 (±1e-6).
- Latency: change I_data 0->255 at t=12 ns (mid-cycle) -> A_out remains 0.0 until the 15 ns edge, then 3.3.
- Async reset: with A_out=3.3, drive rst_n=0 at t=503 ns (between edges) -> A_out=0.0 and A_code=0 at 503 ns, no clock needed; release at 523 ns -> 3.3 after the 525 ns edge.
- Slew (DAC_SLEW_EN, SLEW_STEP=0.1): step 0->255 -> A_out rises 0.1 per clock, reaching 3.3 after 33 clocks; reset during the ramp -> 0.0 immediately.
